// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the loader state encoding and the word-to-byte-address helper.
package loader_pkg;

    localparam int CHECKSUM_W = 32;
    localparam int WORD_BYTES = 4;
    localparam int COUNT_W    = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_RUN    = 3'd3,
        ST_ERROR  = 3'd4
    } loader_state_t;

    // Byte address of word 'idx' in an image that starts at 'base'; never wraps the index.
    function automatic logic [63:0] word_addr(input logic [63:0] base,
                                              input logic [COUNT_W-1:0] idx);
        return base + (64'(idx) * 64'(WORD_BYTES));
    endfunction

endpackage

// File: rtl/loader_checksum.sv
// Running modulo-2^32 additive checksum with synchronous clear and add-enable.
// One copy tracks the streamed image, another the words read back.
module loader_checksum
    import loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_clear,
    input  logic                  i_add,
    input  logic [CHECKSUM_W-1:0] i_operand,
    output logic [CHECKSUM_W-1:0] o_sum
);

    logic [CHECKSUM_W-1:0] r_sum;

    // Clear has priority so a new load never inherits a stale partial sum.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_sum <= '0;
        end else if (i_clear) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_operand;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/imem_program_loader.sv
// Boot loader: streams an instruction image into IMEM, reads it back to verify
// the checksum, then enables the CPU core (or holds it off and flags an error).
module imem_program_loader
    import loader_pkg::*;
#(
    parameter int          MAX_WORDS = 512,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               s_valid,
    input  logic [31:0]        s_data,
    input  logic               s_last,
    output logic               s_ready,
    output logic [63:0]        addr_ext,
    output logic               wen_ext,
    output logic               ren_ext,
    output logic [31:0]        wdata_ext,
    input  logic [31:0]        rdata_ext,
    output logic               cpu_enable,
    output logic               busy,
    output logic               error,
    output logic [COUNT_W-1:0] word_count
);

    localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_WORDS);

    loader_state_t         r_state;
    logic [COUNT_W-1:0]    r_word_count;
    logic [COUNT_W-1:0]    r_rd_idx;
    logic [COUNT_W-1:0]    r_ret_cnt;
    logic [63:0]           r_addr;
    logic [31:0]           r_wdata;
    logic                  r_wen;
    logic                  r_ren;
    logic                  r_ren_d1;

    logic                  w_start;
    logic                  w_handshake;
    logic                  w_full;
    logic                  w_accept;
    logic                  w_overflow;
    logic                  w_issue;
    logic                  w_verify_done;
    logic                  w_sum_match;
    logic [CHECKSUM_W-1:0] w_load_sum;
    logic [CHECKSUM_W-1:0] w_verify_sum;

    assign w_start       = (r_state == ST_IDLE) && start;
    assign w_handshake   = (r_state == ST_LOAD) && s_valid;
    assign w_full        = (r_word_count == MAX_CNT);
    assign w_accept      = w_handshake && !w_full;
    assign w_overflow    = w_handshake && w_full;
    assign w_issue       = (r_state == ST_VERIFY) && (r_rd_idx < r_word_count);
    assign w_verify_done = (r_state == ST_VERIFY) && (r_ret_cnt == r_word_count);
    assign w_sum_match   = (w_load_sum == w_verify_sum);

    // Overflow wins over s_last: a word beyond capacity is never written.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (w_overflow)               r_state <= ST_ERROR;
                    else if (w_accept && s_last)  r_state <= ST_VERIFY;
                end
                ST_VERIFY: begin
                    if (w_verify_done) r_state <= w_sum_match ? ST_RUN : ST_ERROR;
                end
                ST_RUN, ST_ERROR: begin
                    if (stop) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_word_count <= '0;
        end else if (w_start) begin
            r_word_count <= '0;
        end else if (w_accept) begin
            r_word_count <= r_word_count + COUNT_W'(1);
        end
    end

    // Writes and reads share one address register; LOAD and VERIFY never overlap,
    // and the address simply holds when neither strobe fires.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wen   <= 1'b0;
            r_ren   <= 1'b0;
        end else begin
            r_wen <= w_accept;
            r_ren <= w_issue;
            if (w_accept) begin
                r_addr  <= word_addr(BASE_ADDR, r_word_count);
                r_wdata <= s_data;
            end else if (w_issue) begin
                r_addr  <= word_addr(BASE_ADDR, r_rd_idx);
            end
        end
    end

    // Read data lands one cycle after ren; r_ren_d1 marks the cycle it is valid.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_rd_idx  <= '0;
            r_ret_cnt <= '0;
            r_ren_d1  <= 1'b0;
        end else begin
            r_ren_d1 <= r_ren;
            if (w_start) begin
                r_rd_idx  <= '0;
                r_ret_cnt <= '0;
            end else begin
                if (w_issue)  r_rd_idx  <= r_rd_idx + COUNT_W'(1);
                if (r_ren_d1) r_ret_cnt <= r_ret_cnt + COUNT_W'(1);
            end
        end
    end

    loader_checksum u_load_sum (
        .clk       (clk),
        .arst_n    (arst_n),
        .i_clear   (w_start),
        .i_add     (w_accept),
        .i_operand (s_data),
        .o_sum     (w_load_sum)
    );

    loader_checksum u_verify_sum (
        .clk       (clk),
        .arst_n    (arst_n),
        .i_clear   (w_start),
        .i_add     (r_ren_d1),
        .i_operand (rdata_ext),
        .o_sum     (w_verify_sum)
    );

    assign s_ready    = (r_state == ST_LOAD);
    assign busy       = (r_state == ST_LOAD) || (r_state == ST_VERIFY);
    assign error      = (r_state == ST_ERROR);
    assign cpu_enable = (r_state == ST_RUN);
    assign addr_ext   = r_addr;
    assign wen_ext    = r_wen;
    assign ren_ext    = r_ren;
    assign wdata_ext  = r_wdata;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader with a small IMEM model that can
// corrupt one word on readback.
module tb_imem_program_loader;

    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'h0;
    logic        s_last = 1'b0;
    logic [31:0] rdata_ext = 32'h0;
    logic        s_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic        cpu_enable;
    logic        busy;
    logic        error;
    logic [9:0]  word_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] mem [0:15];
    bit          corrupt = 1'b0;
    logic [63:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int          wr_cyc  [$];
    int          rd_count  = 0;
    int          excl_viol = 0;

    logic [31:0] prog [4];

    imem_program_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(64'h0)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .start      (start),
        .stop       (stop),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .addr_ext   (addr_ext),
        .wen_ext    (wen_ext),
        .ren_ext    (ren_ext),
        .wdata_ext  (wdata_ext),
        .rdata_ext  (rdata_ext),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // IMEM model: synchronous write, one-cycle read latency, optional bit-0 flip at 0x8.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wen_ext) mem[addr_ext[5:2]] <= wdata_ext;
        if (ren_ext) rdata_ext <= mem[addr_ext[5:2]] ^ ((corrupt && addr_ext == 64'h8) ? 32'h1 : 32'h0);
    end

    always @(negedge clk) begin
        if (wen_ext) begin
            wr_addr.push_back(addr_ext);
            wr_data.push_back(wdata_ext);
            wr_cyc.push_back(cyc);
        end
        if (ren_ext) rd_count++;
        if (wen_ext && ren_ext) excl_viol++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        rd_count = 0;
    endtask

    task automatic start_load(output int t0);
        start = 1'b1;
        t0 = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_enable(output int seen, output bit found);
        found = 1'b0;
        seen  = -1;
        for (int i = 0; i < 60; i++) begin
            if (cpu_enable) begin
                found = 1'b1;
                seen  = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_error(output int seen, output bit found);
        found = 1'b0;
        seen  = -1;
        for (int i = 0; i < 60; i++) begin
            if (error) begin
                found = 1'b1;
                seen  = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({s_ready, cpu_enable, busy, error, wen_ext, ren_ext} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b expected 000000", {s_ready, cpu_enable, busy, error, wen_ext, ren_ext});
        end
        n_checks++;
        if (addr_ext !== 64'h0 || wdata_ext !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_bus: got addr %h wdata %h expected 0/0", addr_ext, wdata_ext);
        end
        n_checks++;
        if (word_count !== 10'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_count: got %0d expected 0", word_count);
        end
        tick();
        arst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_nominal();
        int  t0, seen;
        bit  found;
        clear_log();
        start_load(t0);
        n_checks++;
        if (s_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL nominal_load_state: got s_ready %b busy %b expected 1/1", s_ready, busy);
        end
        for (int i = 0; i < 4; i++) send_word(prog[i], i == 3);
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL nominal_ready_drop: got %b expected 0", s_ready);
        end
        wait_enable(seen, found);
        n_checks++;
        if (!found || seen - t0 !== 11) begin
            n_fail++;
            $display("[TB] FAIL nominal_latency: got %0d cycles (found %0b) expected 11", seen - t0, found);
        end
        n_checks++;
        if (wr_addr.size() !== 4) begin
            n_fail++;
            $display("[TB] FAIL nominal_write_count: got %0d expected 4", wr_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wr_addr[i] !== 64'(4 * i) || wr_data[i] !== prog[i] || wr_cyc[i] !== t0 + 1 + i) begin
                    n_fail++;
                    $display("[TB] FAIL nominal_write%0d: got addr %h data %h cyc %0d expected %h %h %0d",
                             i, wr_addr[i], wr_data[i], wr_cyc[i] - t0, 64'(4 * i), prog[i], 1 + i);
                end
            end
        end
        n_checks++;
        if (rd_count !== 4 || word_count !== 10'd4 || excl_viol !== 0) begin
            n_fail++;
            $display("[TB] FAIL nominal_verify: got reads %0d count %0d overlap %0d expected 4/4/0", rd_count, word_count, excl_viol);
        end
        pulse_stop();
        n_checks++;
        if (cpu_enable !== 1'b0 || busy !== 1'b0 || word_count !== 10'd4) begin
            n_fail++;
            $display("[TB] FAIL nominal_stop: got en %b busy %b count %0d expected 0/0/4", cpu_enable, busy, word_count);
        end
    endtask

    task automatic test_corrupt();
        int  t0, seen;
        bit  found;
        clear_log();
        corrupt = 1'b1;
        start_load(t0);
        for (int i = 0; i < 4; i++) send_word(prog[i], i == 3);
        wait_error(seen, found);
        n_checks++;
        if (!found || seen - t0 !== 11) begin
            n_fail++;
            $display("[TB] FAIL corrupt_error_time: got %0d cycles (found %0b) expected 11", seen - t0, found);
        end
        tick();
        n_checks++;
        if (error !== 1'b1 || cpu_enable !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL corrupt_flags: got error %b en %b expected 1/0", error, cpu_enable);
        end
        pulse_stop();
        n_checks++;
        if (error !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL corrupt_stop: got error %b busy %b expected 0/0", error, busy);
        end
        corrupt = 1'b0;
    endtask

    task automatic test_overflow();
        int t0;
        clear_log();
        start_load(t0);
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                n_checks++;
                if (error !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL overflow_early_error: got %b expected 0", error);
                end
            end
            send_word(32'h1000_0000 + 32'(i), 1'b0);
        end
        n_checks++;
        if (error !== 1'b1 || cpu_enable !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL overflow_error: got error %b en %b expected 1/0", error, cpu_enable);
        end
        tick();
        n_checks++;
        if (wr_addr.size() !== 8) begin
            n_fail++;
            $display("[TB] FAIL overflow_writes: got %0d expected 8", wr_addr.size());
        end else begin
            n_checks++;
            if (wr_addr[7] !== 64'h1C || wr_data[7] !== 32'h1000_0007) begin
                n_fail++;
                $display("[TB] FAIL overflow_last_write: got addr %h data %h expected 1c 10000007", wr_addr[7], wr_data[7]);
            end
        end
        n_checks++;
        if (word_count !== 10'd8) begin
            n_fail++;
            $display("[TB] FAIL overflow_count: got %0d expected 8", word_count);
        end
        pulse_stop();
    endtask

    task automatic test_gapped();
        int  t0, seen;
        bit  found;
        clear_log();
        start = 1'b1;
        stop  = 1'b1;
        t0 = cyc + 1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL gapped_start_wins: got busy %b expected 1", busy);
        end
        send_word(32'hDEADBEEF, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_checks++;
        if (word_count !== 10'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL gapped_hold: got count %0d busy %b expected 1/1", word_count, busy);
        end
        send_word(32'h12345678, 1'b0);
        send_word(32'h0BADF00D, 1'b1);
        wait_enable(seen, found);
        n_checks++;
        if (!found || seen - t0 !== 11 || word_count !== 10'd3) begin
            n_fail++;
            $display("[TB] FAIL gapped_enable: got %0d cycles (found %0b) count %0d expected 11/3", seen - t0, found, word_count);
        end
        n_checks++;
        if (wr_addr.size() !== 3) begin
            n_fail++;
            $display("[TB] FAIL gapped_write_count: got %0d expected 3", wr_addr.size());
        end else begin
            n_checks++;
            if (wr_addr[0] !== 64'h0 || wr_addr[1] !== 64'h4 || wr_addr[2] !== 64'h8 ||
                wr_cyc[0] - t0 !== 1 || wr_cyc[1] - t0 !== 4 || wr_cyc[2] - t0 !== 5 ||
                wr_data[2] !== 32'h0BADF00D) begin
                n_fail++;
                $display("[TB] FAIL gapped_writes: got %h@%0d %h@%0d %h@%0d expected 0@1 4@4 8@5",
                         wr_addr[0], wr_cyc[0] - t0, wr_addr[1], wr_cyc[1] - t0, wr_addr[2], wr_cyc[2] - t0);
            end
        end
        pulse_stop();
    endtask

    task automatic test_reset_mid_verify();
        int  t0, seen, en_seen;
        bit  found;
        clear_log();
        start_load(t0);
        for (int i = 0; i < 6; i++) send_word(32'hA000_0000 + 32'(i), i == 5);
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b1 || ren_ext !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midverify_pre: got busy %b ren %b expected 1/1", busy, ren_ext);
        end
        #2;
        arst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, cpu_enable, s_ready, ren_ext, wen_ext, error} !== 6'b0 || addr_ext !== 64'h0 || word_count !== 10'd0) begin
            n_fail++;
            $display("[TB] FAIL midverify_reset: got flags %b addr %h count %0d expected 000000/0/0",
                     {busy, cpu_enable, s_ready, ren_ext, wen_ext, error}, addr_ext, word_count);
        end
        tick();
        arst_n = 1'b1;
        en_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (cpu_enable) en_seen++;
            tick();
        end
        n_checks++;
        if (en_seen !== 0) begin
            n_fail++;
            $display("[TB] FAIL midverify_enable_held: got %0d enabled cycles expected 0", en_seen);
        end
        clear_log();
        start_load(t0);
        for (int i = 0; i < 4; i++) send_word(prog[i], i == 3);
        wait_enable(seen, found);
        n_checks++;
        if (!found || seen - t0 !== 11 || word_count !== 10'd4 || wr_addr.size() !== 4) begin
            n_fail++;
            $display("[TB] FAIL midverify_restart: got %0d cycles (found %0b) count %0d writes %0d expected 11/4/4",
                     seen - t0, found, word_count, wr_addr.size());
        end
        pulse_stop();
    endtask

    initial begin
        prog[0] = 32'h00500093;
        prog[1] = 32'h00A00113;
        prog[2] = 32'h002081B3;
        prog[3] = 32'h00000013;
        test_reset();
        test_nominal();
        test_corrupt();
        test_overflow();
        test_gapped();
        test_reset_mid_verify();
        n_checks++;
        if (excl_viol !== 0) begin
            n_fail++;
            $display("[TB] FAIL port_exclusive: got %0d overlapping cycles expected 0", excl_viol);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
